// File: rtl/cla_pkg.sv
// cla_pkg: default sizes, group-count helper and group-vector type for cla_pipe_adder
package cla_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int GW_DEF = 4;
    function automatic int ng(input int width, input int gw);
        return width / gw;
    endfunction
    localparam int NG_DEF = ng(WIDTH_DEF, GW_DEF);
    typedef logic [NG_DEF-1:0] grp_vec_t;
endpackage

// File: rtl/cla_group_pg.sv
// cla_group_pg: bit p/g of one group plus group generate (no carry-in) and group propagate
module cla_group_pg
    import cla_pkg::*;
#(
    parameter int GW = GW_DEF
) (
    input  logic [GW:1] a,
    input  logic [GW:1] b,
    output logic [GW:1] p,
    output logic [GW:1] g,
    output logic        gg,
    output logic        gp
);
    logic [GW:1] chain;
    assign p  = a ^ b;
    assign g  = a & b;
    assign gp = &p;
    assign gg = chain[GW];
    // ripple the generate from the group LSB upward assuming no carry enters the group
    always_comb begin
        chain = '0;
        chain[1] = g[1];
        for (int f = 2; f <= GW; f++) chain[f] = g[f] | (p[f] & chain[f-1]);
    end
endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: 3-stage pipelined carry-lookahead adder with valid/ready on both sides.
// Define CLA_APPROX_CARRY_EN for truncated group-carry lookahead (approximate result).
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int GW = GW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:1]   a,
    input  logic [WIDTH:1]   b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:1]   sum,
    output logic             cout
);
    localparam int NG = ng(WIDTH, GW);

    logic           v1, v2, v3, r1, r2, r3;
    logic [WIDTH:1] p1, g1, s1_p, s1_g, s2_p, s2_g, cy;
    logic [NG-1:0]  gg1, gp1, s1_gg, s1_gp;
    logic [NG:0]    c, s2_c;
    logic           s1_cin;

    assign r3        = !v3 || out_ready;
    assign r2        = !v2 || r3;
    assign r1        = !v1 || r2;
    assign in_ready  = r1;
    assign out_valid = v3;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group_pg #(.GW(GW)) u_pg (
            .a  (a[k*GW+GW:k*GW+1]),
            .b  (b[k*GW+GW:k*GW+1]),
            .p  (p1[k*GW+GW:k*GW+1]),
            .g  (g1[k*GW+GW:k*GW+1]),
            .gg (gg1[k]),
            .gp (gp1[k])
        );
    end

    // group carries from registered GG/GP; approximate build drops the GP chain except at cout
    always_comb begin
        c = '0;
        c[0] = s1_cin;
        for (int k = 1; k <= NG; k++)
`ifdef CLA_APPROX_CARRY_EN
            c[k] = (k == NG) ? (s1_gg[k-1] | (s1_gp[k-1] & c[k-1])) : s1_gg[k-1];
`else
            c[k] = s1_gg[k-1] | (s1_gp[k-1] & c[k-1]);
`endif
    end

    // bit carries rippled inside each group starting from that group's carry-in
    always_comb begin
        cy = '0;
        for (int k = 0; k < NG; k++) begin
            cy[k*GW+1] = s2_c[k];
            for (int j = 2; j <= GW; j++)
                cy[k*GW+j] = s2_g[k*GW+j-1] | (s2_p[k*GW+j-1] & cy[k*GW+j-1]);
        end
    end

    // stage 1: capture bit p/g, group GG/GP and carry-in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            s1_p <= '0;
            s1_g <= '0;
            s1_gg <= '0;
            s1_gp <= '0;
            s1_cin <= 1'b0;
        end else begin
            if (r1) v1 <= in_valid;
            if (r1 && in_valid) begin
                s1_p <= p1;
                s1_g <= g1;
                s1_gg <= gg1;
                s1_gp <= gp1;
                s1_cin <= cin;
            end
        end
    end

    // stage 2: capture resolved group carries with bit p/g carried forward
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            s2_p <= '0;
            s2_g <= '0;
            s2_c <= '0;
        end else begin
            if (r2) v2 <= v1;
            if (r2 && v1) begin
                s2_p <= s1_p;
                s2_g <= s1_g;
                s2_c <= c;
            end
        end
    end

    // stage 3: form the sum and carry-out, held while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3 <= 1'b0;
            sum <= '0;
            cout <= 1'b0;
        end else begin
            if (r3) v3 <= v2;
            if (r3 && v2) begin
                sum <= s2_p ^ cy;
                cout <= s2_c[NG];
            end
        end
    end
endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- 3-stage pipelined carry-lookahead adder. It is the downstream consumer of per-group generate/propagate logic.
- Stage 1 forms per-group generate (GG) and propagate (GP), stage 2 resolves the group carries, stage 3 forms the sum.
- Valid/ready handshake on both sides; slots between operand sources and approximate-arithmetic datapaths.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of GW.
- GW, 4, group width in bits. NG = WIDTH/GW groups.

Ports:
- clk  input  1  clock; all registers update on the rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operands a, b and cin are valid
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A; bits indexed [WIDTH:1], bit 1 is the LSB
- b  input  WIDTH  operand B; bits indexed [WIDTH:1]
- cin  input  1  carry-in to group 0
- out_valid  output  1  sum and cout are valid
- out_ready  input  1  downstream accepts the result
- sum  output  WIDTH  result, indexed [WIDTH:1]
- cout  output  1  carry out of the top group

Behaviour:
- Reset (async, rst=1): all stage valid bits = 0 and all data registers = 0. Hence out_valid=0, sum=0, cout=0, in_ready=1 once rst is deasserted.
- Handshake:
  - A transfer occurs when valid && ready are both 1 in the same cycle.
  - ready_k = !valid_k || ready_(k+1), with ready_4 = out_ready and in_ready = ready_1.
  - A stage loads only when its ready_k = 1.
  - Fully combinational ready chain, so there are no bubbles; throughput is 1 result per cycle.
- Latency: operands accepted in cycle N give out_valid in cycle N+3 if never stalled.
- Stall: while out_valid && !out_ready, sum and cout hold stable and no stage overwrites an occupied stage.
- Stage 1 (per bit f, per group k):
  - p[f] = a^b, g[f] = a&b.
  - Within group k, GG is a ripple chain with no carry-in: gg[lsb] = g[lsb]; gg[f] = g[f] | (p[f] & gg[f-1]); GG[k] = gg[msb].
  - GP[k] = AND of p over the group.
  - Register p, GG, GP and cin.
- Stage 2: c[0] = cin; c[k] = GG[k-1] | (GP[k-1] & c[k-1]) for k = 1..NG. Register p, the group carry-ins c[0..NG-1] and c[NG].
- Stage 3: inside each group, ripple the bit carries from c[k] using the registered p and g; sum[f] = p[f] ^ carry[f]; cout = c[NG].
  - Stage 2 therefore also carries g (or a, b) forward.
- Arithmetic: modulo 2^WIDTH. {cout, sum} = a + b + cin exactly (default build).
- Simultaneous accept at input and drain at output in the same cycle is legal. Occupancy stays constant.
- Reset mid-operation: all in-flight results are discarded. No partial output appears after rst deasserts.

Optional Feature:
- Macro: CLA_APPROX_CARRY_EN.
- Defined:
  - Stage 2 uses truncated lookahead: c[0] = cin; c[k] = GG[k-1] for k ≥ 1, i.e. the GP chain is ignored.
  - cout = GG[NG-1] | (GP[NG-1] & c[NG-1]).
  - The result may be wrong whenever a carry must propagate across a whole group. Latency and handshake are unchanged.
- Undefined: exact carry-lookahead as described above.

Decomposition:
- Package cla_pkg:
  - default WIDTH/GW constants;
  - function ng(WIDTH, GW);
  - a group-vector typedef sized by NG.
- Sub-module cla_group_pg, instantiated NG times in stage 1:
  - parameter GW;
  - inputs a, b slices;
  - outputs GG, GP and the p, g bit vectors.

Test Plan:
1. Reset: assert rst mid-stream with 3 results in flight -> out_valid=0, sum=0, cout=0 immediately; no stale output after release.
2. Single add: a=0x1234, b=0x4321, cin=0 -> out_valid 3 cycles later with sum=0x5555, cout=0.
3. Wrap-around: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
4. Throughput/backpressure:
   - Stream 8 random pairs with out_ready=1 -> one result per cycle, in order.
   - Then hold out_ready=0 for 5 cycles -> in_ready drops after 3 accepts, sum holds stable, no loss or duplication on release.
5. Approximate mode (CLA_APPROX_CARRY_EN defined): a=0x00FF, b=0x0001, cin=0 -> sum=0x0000, cout=0.
   - The exact build gives sum=0x0100.
   - Random pairs with no group-spanning propagate match the exact result.
6. Exhaustive check with WIDTH=8, GW=4: all 2^17 combinations of a, b and cin -> {cout, sum} == a+b+cin in the default build.
